// File: rtl/fp_unit_issuer.sv
// fp_unit_issuer: initiator for the go/done trigger protocol of a fixed-latency FP unit.
// The unit cannot be stalled. Credits therefore bound the result FIFO, and after
// reset a flush phase discards stale dones that are still in the unit's pipeline.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   req_valid/ready     operand request handshake (req_a, req_b)
//   rsp_valid/ready     result response handshake (rsp_data = FIFO head)
//   unit_go             go trigger to the unit (combinational, equals the request handshake)
//   unit_a, unit_b      operands to the unit (passthrough of req_a, req_b)
//   unit_done           done trigger from the unit; unit_result is valid with it
//   err                 sticky protocol error (unexpected or missing done, FIFO overrun)
module fp_unit_issuer #(
    parameter int unsigned LATENCY = 14,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             unit_go,
    output logic [WIDTH-1:0] unit_a,
    output logic [WIDTH-1:0] unit_b,
    input  logic             unit_done,
    input  logic [WIDTH-1:0] unit_result,
    output logic             err
);

    localparam int unsigned OCC_W  = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FCNT_W = $clog2(LATENCY + 1);

    typedef enum logic {
        FLUSH = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [FCNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [OCC_W-1:0]   occ_q;
    logic [OCC_W-1:0]   fifo_count_q;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LATENCY-1:0] exp_sr_q;
    logic [WIDTH-1:0]   mem [DEPTH];

    logic run, fire, deq, fifo_full, exp_done, wr_en, done_err;

    // Pointer advance, wrapping modulo DEPTH (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= FLUSH;
            flush_cnt_q <= FCNT_W'(LATENCY);
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next state and request acceptance.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        req_ready   = 1'b0;
        case (state_q)
            FLUSH: begin
                flush_cnt_d = flush_cnt_q - FCNT_W'(1);
                if (flush_cnt_q == FCNT_W'(1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // A same-cycle dequeue is deliberately not credited here.
                req_ready = (occ_q != OCC_W'(DEPTH));
            end
            default: state_d = FLUSH;
        endcase
    end

    assign run       = (state_q == RUN);
    assign fire      = req_valid & req_ready;
    assign unit_go   = fire;
    assign unit_a    = req_a;
    assign unit_b    = req_b;
    assign rsp_valid = (fifo_count_q != '0);
    assign rsp_data  = mem[rd_ptr_q];
    assign deq       = rsp_valid & rsp_ready;
    assign fifo_full = (fifo_count_q == OCC_W'(DEPTH));
    assign exp_done  = exp_sr_q[LATENCY-1];
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_en     = run & unit_done & (~fifo_full | deq);
    assign done_err  = run & ((unit_done != exp_done) | (unit_done & fifo_full & ~deq));

    // Credits, expected-done pipeline, FIFO bookkeeping and the sticky error flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            occ_q        <= '0;
            exp_sr_q     <= '0;
            fifo_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            err          <= 1'b0;
        end else begin
            case ({fire, deq})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase

            exp_sr_q <= (exp_sr_q << 1) | LATENCY'(fire);

            case ({wr_en, deq})
                2'b10:   fifo_count_q <= fifo_count_q + OCC_W'(1);
                2'b01:   fifo_count_q <= fifo_count_q - OCC_W'(1);
                default: fifo_count_q <= fifo_count_q;
            endcase

            if (wr_en) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (deq) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (done_err) begin
                err <= 1'b1;
            end
        end
    end

    // Result storage; contents need no reset because fifo_count gates visibility.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= unit_result;
        end
    end

endmodule

// File: tb/tb_fp_unit_issuer.sv
// Testbench for fp_unit_issuer. The bench plays the FP unit: a queue of in-flight ops
// whose dones appear LATENCY cycles after issue and which survive reset. A
// transaction-level model predicts the handshakes, the in-order response data and err.
module tb_fp_unit_issuer;

    localparam int unsigned LAT = 14;
    localparam int unsigned W   = 32;
    localparam int unsigned DEP = 16;

    logic         clock, reset;
    logic         req_valid, req_ready;
    logic [W-1:0] req_a, req_b;
    logic         rsp_valid, rsp_ready;
    logic [W-1:0] rsp_data;
    logic         unit_go;
    logic [W-1:0] unit_a, unit_b;
    logic         unit_done;
    logic [W-1:0] unit_result;
    logic         err;

    fp_unit_issuer #(.LATENCY(LAT), .WIDTH(W), .DEPTH(DEP)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .unit_go     (unit_go),
        .unit_a      (unit_a),
        .unit_b      (unit_b),
        .unit_done   (unit_done),
        .unit_result (unit_result),
        .err         (err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        int           due;
        logic [W-1:0] val;
    } op_t;

    int           vectors = 0;
    int           miscompares = 0;

    op_t          inflight[$];   // ops inside the unit (unaffected by reset)
    int           exp_due[$];    // cycles at which a done is legitimately expected
    logic [W-1:0] rsp_q[$];      // results the issuer should be holding, in order
    int           cyc = 0;
    int           since_rst = 0;
    int           outstanding = 0;
    int           total_deq = 0;
    logic         err_exp = 1'b0;
    logic         last_fire;
    logic         obs_rdy;
    logic         spur = 1'b0;
    logic [W-1:0] spur_val = '0;

    // Stand-in arithmetic for the unit; 1.0 + 2.0 = 3.0 is the directed case.
    function automatic logic [W-1:0] unit_fn(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a + b;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive the unit, check outputs at the falling edge, advance the model.
    task automatic cycle();
        logic run, rdy_exp, fire, deq, exp_now, wr;
        int   tmp;
        op_t  o;
        unit_done   = 1'b0;
        unit_result = W'($urandom());
        if (inflight.size() != 0 && inflight[0].due == cyc) begin
            o = inflight.pop_front();
            unit_done   = 1'b1;
            unit_result = o.val;
        end
        if (spur) begin
            unit_done   = 1'b1;
            unit_result = spur_val;
        end
        if (reset) begin
            rsp_q.delete();
            exp_due.delete();
            outstanding = 0;
            err_exp     = 1'b0;
            since_rst   = 0;
        end
        @(negedge clock);
        run     = !reset && (since_rst >= int'(LAT));
        rdy_exp = run && (outstanding < int'(DEP));
        obs_rdy = req_ready;
        check("req_ready", W'(req_ready), W'(rdy_exp));
        check("unit_go", W'(unit_go), W'(req_valid && rdy_exp));
        check("rsp_valid", W'(rsp_valid), W'(rsp_q.size() != 0));
        if (rsp_q.size() != 0) check("rsp_data", rsp_data, rsp_q[0]);
        check("err", W'(err), W'(err_exp));
        if (req_valid && rdy_exp) begin
            check("unit_a", unit_a, req_a);
            check("unit_b", unit_b, req_b);
        end
        fire = 1'b0;
        if (!reset) begin
            fire    = req_valid && rdy_exp;
            deq     = rsp_ready && (rsp_q.size() != 0);
            exp_now = 1'b0;
            if (exp_due.size() != 0 && exp_due[0] == cyc) begin
                tmp     = exp_due.pop_front();
                exp_now = 1'b1;
            end
            wr = 1'b0;
            if (run) begin
                if (unit_done != exp_now) err_exp = 1'b1;
                if (unit_done) begin
                    if (rsp_q.size() < int'(DEP) || deq) wr = 1'b1;
                    else err_exp = 1'b1;
                end
            end
            if (deq) begin
                void'(rsp_q.pop_front());
                total_deq++;
            end
            if (wr) rsp_q.push_back(unit_result);
            if (fire) begin
                inflight.push_back('{due: cyc + int'(LAT), val: unit_fn(req_a, req_b)});
                exp_due.push_back(cyc + int'(LAT));
            end
            outstanding = outstanding + (fire ? 1 : 0) - (deq ? 1 : 0);
            since_rst++;
        end
        last_fire = fire;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic drain(input logic rr);
        int n = 0;
        req_valid = 1'b0;
        rsp_ready = rr;
        while ((inflight.size() != 0 || (rr && rsp_q.size() != 0)) && n < 200) begin
            cycle();
            n++;
        end
    endtask

    task automatic pulse_reset();
        req_valid = 1'b0;
        reset     = 1'b1;
        cycle();
        reset     = 1'b0;
    endtask

    initial begin
        int n, acc, stalls, d0;
        reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        unit_done = 1'b0; unit_result = '0;
        @(posedge clock);
        #1;
        cycle();
        cycle();
        reset = 1'b0;

        // Flush phase: no acceptance for LATENCY cycles, then ready.
        repeat (LAT) cycle();
        rsp_ready = 1'b1;
        repeat (5) cycle();

        // Single op: 1.0 + 2.0, response LATENCY+1 cycles after acceptance.
        req_valid = 1'b1; req_a = 32'h3F80_0000; req_b = 32'h4000_0000;
        cycle();
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 40) begin
            cycle();
            n++;
        end
        check("single_latency", W'(n), W'(LAT + 1));
        check("single_data", rsp_data, 32'h4040_0000);
        drain(1'b1);

        // Streaming: 64 back-to-back requests with rsp_ready held high.
        d0 = total_deq; acc = 0; stalls = 0; n = 0;
        rsp_ready = 1'b1;
        while (acc < 64 && n < 200) begin
            req_valid = 1'b1; req_a = W'($urandom()); req_b = W'($urandom());
            cycle();
            if (!obs_rdy) stalls++;
            if (last_fire) acc++;
            n++;
        end
        drain(1'b1);
        check("stream_stalls", W'(stalls), W'(0));
        check("stream_results", W'(total_deq - d0), W'(64));

        // Backpressure: exactly DEPTH accepted, then one refill per dequeue.
        acc = 0;
        rsp_ready = 1'b0;
        repeat (DEP + 20) begin
            req_valid = 1'b1; req_a = W'($urandom()); req_b = W'($urandom());
            cycle();
            if (last_fire) acc++;
        end
        check("bp_accepts", W'(acc), W'(DEP));
        rsp_ready = 1'b1;
        repeat (30) begin
            req_a = W'($urandom()); req_b = W'($urandom());
            cycle();
        end
        drain(1'b1);

        // Random traffic.
        repeat (300) begin
            req_valid = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 1) != 0);
            req_a = W'($urandom()); req_b = W'($urandom());
            cycle();
        end
        drain(1'b1);

        // Reset with 10 ops in flight: their dones fall into the flush window.
        rsp_ready = 1'b1;
        repeat (10) begin
            req_valid = 1'b1; req_a = W'($urandom()); req_b = W'($urandom());
            cycle();
        end
        pulse_reset();
        repeat (LAT) cycle();
        check("flush_left_unit_idle", W'(inflight.size()), W'(0));
        repeat (8) begin
            req_valid = 1'b1; req_a = W'($urandom()); req_b = W'($urandom());
            cycle();
        end
        drain(1'b1);

        // FIFO full: spurious done dropped, then done with same-cycle dequeue is stored.
        rsp_ready = 1'b0;
        repeat (DEP) begin
            req_valid = 1'b1; req_a = W'($urandom()); req_b = W'($urandom());
            cycle();
        end
        drain(1'b0);
        spur = 1'b1; spur_val = 32'hDEAD_0001; rsp_ready = 1'b0;
        cycle();
        spur_val = 32'hBEEF_0002; rsp_ready = 1'b1;
        cycle();
        spur = 1'b0;
        d0 = total_deq;
        drain(1'b1);
        check("full_wr_rd_count", W'(total_deq - d0), W'(DEP));
        check("err_sticky", W'(err), W'(1));

        // Reset clears err; a missing done then sets it.
        pulse_reset();
        repeat (LAT + 2) cycle();
        req_valid = 1'b1; req_a = W'($urandom()); req_b = W'($urandom());
        cycle();
        req_valid = 1'b0;
        if (inflight.size() != 0) void'(inflight.pop_back());
        repeat (LAT + 4) cycle();
        check("err_missing_done", W'(err), W'(1));

        // Spurious done with nothing issued.
        pulse_reset();
        repeat (LAT + 3) cycle();
        rsp_ready = 1'b0;
        spur = 1'b1; spur_val = 32'h1234_5678;
        cycle();
        spur = 1'b0;
        rsp_ready = 1'b1;
        repeat (4) cycle();
        check("err_spurious", W'(err), W'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
